reset_pulse_gen: RTL
====================

Name: reset_pulse_gen

Overview:
Originator side of the system reset path. Produces a clean, registered, active-high reset request of guaranteed minimum width from three sources: power-on, software request, and an internal watchdog. The output drives the raw reset input of the reset synchronizer/debouncer. It is held long enough to pass that block's 3-sample qualification, and is followed by a hold-off window so back-to-back requests cannot chatter.

Parameters:
PULSE_CYCLES, 16, o_rst high time in i_clk cycles; legal range >= 3.
HOLDOFF_CYCLES, 8, cycles after o_rst falls during which new requests are not serviced; legal range >= 1.
WDT_CYCLES, 1024, watchdog timeout in cycles of i_wdt_en high without a kick; legal range >= 2.

Ports:
i_clk  input  1  system clock, all logic on posedge.
i_rst_n  input  1  asynchronous, active-low reset (power-on); one clock; reset is asynchronous and active-low.
i_sw_req  input  1  synchronous software reset request, sampled each cycle.
i_wdt_en  input  1  watchdog enable; counter runs only while high.
i_wdt_kick  input  1  watchdog restart strobe.
o_rst  output  1  registered active-high reset request.
o_busy  output  1  high in ASSERT or HOLDOFF.
o_cause  output  2  cause of the last o_rst pulse: 0 = POR, 1 = SW, 2 = WDT; 3 is never driven.

Behaviour:
- Counter widths: $clog2 of the respective parameter, with a minimum of 1 bit. Counters saturate at terminal and never wrap.
- States: ASSERT, HOLDOFF, IDLE.
- Async reset (i_rst_n low), applied immediately and independent of i_clk:
  - state = ASSERT, o_rst = 1, o_busy = 1, o_cause = 0.
  - Pulse, hold-off and watchdog counters = 0; pending flag = 0.
- ASSERT:
  - o_rst = 1 for exactly PULSE_CYCLES rising edges, counted from the entry edge or from reset release.
  - Then o_rst = 0 and state -> HOLDOFF.
  - i_sw_req and watchdog expiry are dropped; the watchdog counter is held at 0.
- HOLDOFF:
  - o_rst = 0 and o_busy = 1 for HOLDOFF_CYCLES cycles, then state -> IDLE.
  - Watchdog counter is held at 0.
  - i_sw_req high on any cycle sets a one-deep pending flag; further requests do not stack.
- IDLE:
  - o_busy = 0.
  - A trigger is i_sw_req = 1, the pending flag set, or a watchdog expiry.
  - On a trigger: on the same edge state -> ASSERT, o_rst = 1, o_cause updated, pending cleared. Latency is 1 edge from the sampled request to o_rst high.
  - Simultaneous watchdog expiry and SW request/pending: WDT wins, o_cause = 2, pending cleared, one pulse only.
- Watchdog (IDLE only):
  - If i_wdt_en = 0, the counter is cleared.
  - Else if i_wdt_kick = 1, the counter is cleared; a kick on the expiry cycle wins and there is no expiry.
  - Else the counter increments.
  - Expiry is the cycle the counter equals WDT_CYCLES-1 with i_wdt_en = 1 and no kick.
- o_cause changes only on entry to ASSERT and holds its value until the next pulse.
- Reset asserted mid-pulse or mid-holdoff restarts from POR: full PULSE_CYCLES after release, o_cause = 0.

Optional Feature:
RESET_PULSE_GEN_WDT_WARN_EN:
- Defined: adds output o_wdt_warn, 1 bit, registered, reset 0.
  - It is high while in IDLE with i_wdt_en = 1 and the watchdog counter >= WDT_CYCLES/2 (integer division).
  - It clears on the same edge the counter clears.
- Undefined: the port and comparator are absent; all other behaviour is identical.

Test Plan:
1. POR, defaults: hold i_rst_n = 0 for 5 cycles, then release -> o_rst = 1 and o_cause = 0 immediately; o_rst stays high 16 edges after release; o_busy falls 8 cycles after o_rst falls.
2. SW request: in IDLE, pulse i_sw_req for 1 cycle -> o_rst high from the next edge for exactly 16 cycles; o_cause = 1.
3. Request handling: i_sw_req during ASSERT -> ignored; i_sw_req for 3 cycles during HOLDOFF -> exactly one extra 16-cycle pulse starting on the first IDLE edge.
4. Watchdog, WDT_CYCLES = 32: i_wdt_en = 1 with no kick -> o_rst rises 32 edges after entering IDLE, o_cause = 2; kicking every 20 cycles -> no pulse over 500 cycles.
5. Collision: watchdog expiry and i_sw_req on the same cycle -> a single pulse with o_cause = 2 and no follow-up pulse.
6. Mid-pulse reset: assert i_rst_n = 0 at cycle 7 of a WDT pulse -> o_cause = 0 and a full 16-cycle pulse after release; with WARN_EN and WDT_CYCLES = 32, o_wdt_warn rises after 16 unkicked IDLE cycles.

Source files
------------

// File: rtl/reset_pulse_gen.sv
// -----------------------------------------------------------------------------
// reset_pulse_gen
//
// Originator of the system reset request. Produces a registered, active-high
// reset pulse of PULSE_CYCLES clock cycles from three sources: power-on
// (i_rst_n), a software request (i_sw_req) and an internal watchdog. Each
// pulse is followed by a HOLDOFF_CYCLES quiet window. A software request that
// arrives during that window is remembered in a one-deep pending flag and
// serviced on the first idle cycle.
//
// Ports
//   i_clk       system clock, all logic on the rising edge
//   i_rst_n     asynchronous active-low power-on reset
//   i_sw_req    synchronous software reset request, sampled every cycle
//   i_wdt_en    watchdog enable; the watchdog counts only while this is high
//   i_wdt_kick  watchdog restart strobe
//   o_rst       registered active-high reset request
//   o_busy      high while a pulse or its hold-off window is in progress
//   o_cause     source of the last pulse: 0 = POR, 1 = SW, 2 = WDT
//   o_wdt_warn  (only with RESET_PULSE_GEN_WDT_WARN_EN) watchdog half-way flag
//
// Build option
//   RESET_PULSE_GEN_WDT_WARN_EN  adds the registered o_wdt_warn output, which
//   is high while idle once the watchdog counter has reached WDT_CYCLES/2.
// -----------------------------------------------------------------------------
module reset_pulse_gen #(
  parameter int PULSE_CYCLES   = 16,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int WDT_CYCLES     = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sw_req,
  input  logic       i_wdt_en,
  input  logic       i_wdt_kick,
  output logic       o_rst,
  output logic       o_busy,
  output logic [1:0] o_cause
`ifdef RESET_PULSE_GEN_WDT_WARN_EN
  ,
  output logic       o_wdt_warn
`endif
);

  // Counter widths; a parameter of 1 would give $clog2 = 0, so floor at 1 bit.
  localparam int PW = (PULSE_CYCLES   > 1) ? $clog2(PULSE_CYCLES)   : 1;
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int WW = (WDT_CYCLES     > 1) ? $clog2(WDT_CYCLES)     : 1;

  localparam logic [PW-1:0] PULSE_TERM = PW'(PULSE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_TERM  = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [WW-1:0] WDT_TERM   = WW'(WDT_CYCLES - 1);

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_SW  = 2'd1;
  localparam logic [1:0] CAUSE_WDT = 2'd2;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLDOFF = 2'd1,
    ST_IDLE    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [WW-1:0]   wdt_cnt_q, wdt_cnt_d;
  logic            pending_q, pending_d;
  logic [1:0]      cause_q, cause_d;
  logic            rst_q, rst_d;
  logic            busy_q, busy_d;
  logic            wdt_expire_s;

  // Next-state logic for the pulse FSM, its counters, the pending flag and the watchdog.
  always_comb begin
    state_d      = state_q;
    pulse_cnt_d  = pulse_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    wdt_cnt_d    = wdt_cnt_q;
    pending_d    = pending_q;
    cause_d      = cause_q;
    wdt_expire_s = 1'b0;

    case (state_q)
      ST_ASSERT: begin
        // Requests and watchdog are ignored while the pulse is out.
        wdt_cnt_d = '0;
        if (pulse_cnt_q == PULSE_TERM) begin
          state_d    = ST_HOLDOFF;
          hold_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PW'(1);
        end
      end

      ST_HOLDOFF: begin
        wdt_cnt_d = '0;
        // One-deep: repeated requests collapse into a single pending pulse.
        if (i_sw_req) begin
          pending_d = 1'b1;
        end else begin
          pending_d = pending_q;
        end
        if (hold_cnt_q == HOLD_TERM) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end

      ST_IDLE: begin
        // Watchdog: a kick on the terminal cycle suppresses the expiry.
        if (!i_wdt_en) begin
          wdt_cnt_d = '0;
        end else if (i_wdt_kick) begin
          wdt_cnt_d = '0;
        end else if (wdt_cnt_q == WDT_TERM) begin
          wdt_expire_s = 1'b1;
          wdt_cnt_d    = wdt_cnt_q;
        end else begin
          wdt_cnt_d = wdt_cnt_q + WW'(1);
        end

        // Watchdog expiry takes priority over a software request.
        if (wdt_expire_s) begin
          state_d     = ST_ASSERT;
          cause_d     = CAUSE_WDT;
          pending_d   = 1'b0;
          pulse_cnt_d = '0;
          wdt_cnt_d   = '0;
        end else if (i_sw_req || pending_q) begin
          state_d     = ST_ASSERT;
          cause_d     = CAUSE_SW;
          pending_d   = 1'b0;
          pulse_cnt_d = '0;
          wdt_cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        // Unreachable encoding: recover by issuing a fresh pulse.
        state_d     = ST_ASSERT;
        pulse_cnt_d = '0;
        wdt_cnt_d   = '0;
        pending_d   = 1'b0;
      end
    endcase

    rst_d  = (state_d == ST_ASSERT);
    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and registered output flops; reset starts a POR pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_ASSERT;
      pulse_cnt_q <= '0;
      hold_cnt_q  <= '0;
      wdt_cnt_q   <= '0;
      pending_q   <= 1'b0;
      cause_q     <= CAUSE_POR;
      rst_q       <= 1'b1;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      wdt_cnt_q   <= wdt_cnt_d;
      pending_q   <= pending_d;
      cause_q     <= cause_d;
      rst_q       <= rst_d;
      busy_q      <= busy_d;
    end
  end

  assign o_rst   = rst_q;
  assign o_busy  = busy_q;
  assign o_cause = cause_q;

`ifdef RESET_PULSE_GEN_WDT_WARN_EN
  localparam logic [WW-1:0] WARN_TH = WW'(WDT_CYCLES / 2);

  logic warn_q, warn_d;

  // Warning follows the next counter value, so it drops on the edge the counter clears.
  always_comb begin
    if ((state_d == ST_IDLE) && (wdt_cnt_d >= WARN_TH)) begin
      warn_d = 1'b1;
    end else begin
      warn_d = 1'b0;
    end
  end

  // Warning output register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign o_wdt_warn = warn_q;
`else
  // Without the warning option there is no comparator and no extra output.
`endif

endmodule
